// File: rtl/y86_pkg.sv
// Shared Y86 pipeline constants: instruction codes, register IDs, status codes
// and the exception classifier used by every stage register.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [2:0] SBUB = 3'd0;
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  // Full-width compare so that unknown codes wider than 3 bits fall back to "no exception".
  function automatic logic is_exc(input logic [31:0] stat);
    case (stat)
      32'd2, 32'd3, 32'd4: is_exc = 1'b1;
      default:             is_exc = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count qualified events, holding at the maximum value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/em_stage_reg.sv
// Execute-to-memory pipeline register with stall/bubble control, sticky
// exception squash, control-conflict flag and saturating event counters.
module em_stage_reg
  import y86_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int ICODE_W = 4,
  parameter int REG_W   = 4,
  parameter int STAT_W  = 3,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               M_stall,
  input  logic               M_bubble,
  input  logic               clr_exc,
  input  logic [STAT_W-1:0]  e_stat,
  input  logic [ICODE_W-1:0] e_icode,
  input  logic               e_cnd,
  input  logic [DATA_W-1:0]  e_valE,
  input  logic [DATA_W-1:0]  e_valA,
  input  logic [REG_W-1:0]   e_dstE,
  input  logic [REG_W-1:0]   e_dstM,
  output logic [STAT_W-1:0]  M_stat,
  output logic [ICODE_W-1:0] M_icode,
  output logic               M_cnd,
  output logic [DATA_W-1:0]  M_valE,
  output logic [DATA_W-1:0]  M_valA,
  output logic [REG_W-1:0]   M_dstE,
  output logic [REG_W-1:0]   M_dstM,
  output logic               M_exc,
  output logic               M_ctl_err,
  output logic [CNT_W-1:0]   M_stall_cnt,
  output logic [CNT_W-1:0]   M_bubble_cnt
);

  logic bubble_s;
  logic load_s;
  logic stall_inc_s;
  logic e_exc_s;

  // A pending exception squashes younger instructions unless a stall is holding the excepting one.
  assign bubble_s    = M_bubble | (M_exc & ~M_stall);
  assign load_s      = ~bubble_s & ~M_stall;
  assign stall_inc_s = M_stall & ~bubble_s;
  assign e_exc_s     = is_exc(32'(e_stat));

  // Stage contents: bubble beats stall beats load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      M_stat  <= STAT_W'(SBUB);
      M_icode <= ICODE_W'(INOP);
      M_cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= REG_W'(RNONE);
      M_dstM  <= REG_W'(RNONE);
    end else if (bubble_s) begin
      M_stat  <= STAT_W'(SBUB);
      M_icode <= ICODE_W'(INOP);
      M_cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= REG_W'(RNONE);
      M_dstM  <= REG_W'(RNONE);
    end else if (load_s) begin
      M_stat  <= e_stat;
      M_icode <= e_icode;
      M_cnd   <= e_cnd;
      M_valE  <= e_valE;
      M_valA  <= e_valA;
      M_dstE  <= e_dstE;
      M_dstM  <= e_dstM;
    end
  end

  // Sticky exception: a freshly loaded excepting status overrides a clear on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      M_exc <= 1'b0;
    end else if (load_s && e_exc_s) begin
      M_exc <= 1'b1;
    end else if (clr_exc) begin
      M_exc <= 1'b0;
    end
  end

  // Conflicting stall+bubble requests are latched until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      M_ctl_err <= 1'b0;
    end else if (M_stall && M_bubble) begin
      M_ctl_err <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc_s),
    .count (M_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bubble_s),
    .count (M_bubble_cnt)
  );

endmodule
